// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
//   Shared types and constants for the OLED (SSD1331) display path.
//   - oled_entry_t  : one queued byte together with its data/command flag.
//   - queue_state_t : states of the oled_byte_queue transmit sequencer.
//   - CMD_*         : frequently used SSD1331 command bytes.
// ---------------------------------------------------------------------------
package oled_pkg;

  // dc = 0 marks a command byte, dc = 1 a data byte.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } oled_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    START,
    WAIT_DONE,
    HOLD
  } queue_state_t;

  // SSD1331 command bytes shared by the controller and its tests.
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_REMAP       = 8'hA0;
  localparam logic [7:0] CMD_SET_COLUMN  = 8'h15;
  localparam logic [7:0] CMD_SET_ROW     = 8'h75;

  // A zero-length CS gap is not meaningful; treat it as one cycle.
  function automatic int unsigned at_least_one(input int unsigned value);
    return (value == 0) ? 1 : value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock circular FIFO with show-ahead read data.
//   Pointers are one bit wider than the index so full and empty can be told
//   apart; level is simply wr_ptr - rd_ptr.
//
//   Ports
//     clk, reset  : clock and synchronous active-high reset (empties FIFO)
//     push        : write push_data when not full (ignored when full)
//     push_data   : entry to write
//     pop         : discard the head entry when not empty
//     pop_data    : current head entry (valid while empty = 0)
//     full, empty : occupancy flags
//     level       : number of stored entries (0 .. DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Read comes from storage only, so a new entry shows up one cycle after
  // its push rather than falling straight through.
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/oled_byte_queue.sv
// ---------------------------------------------------------------------------
// oled_byte_queue
//   Buffered byte transmitter between the OLED controller and spi_master.
//   The controller pushes (byte, dc) entries into a FIFO; this block drains
//   them through spi_master's start/ready/done handshake and owns the cs/dc
//   framing, including the CS setup gap before a burst and the CS hold gap
//   after it. A push arriving during the hold gap extends the burst.
//
//   Ports
//     clk, reset   : clock and synchronous active-high reset
//     wr_valid     : push request; a push happens on wr_valid && wr_ready
//     wr_data      : byte to send
//     wr_dc        : 0 = command, 1 = data
//     wr_ready     : FIFO not full
//     level        : FIFO occupancy
//     busy         : sequencer active or bytes still queued
//     spi_ready    : spi_master idle
//     spi_done     : one-cycle pulse at end of a byte
//     spi_start    : one-cycle start pulse to spi_master
//     spi_d_in     : byte presented to spi_master
//     cs           : OLED chip select, active low
//     dc           : OLED data/command select
// ---------------------------------------------------------------------------
module oled_byte_queue
  import oled_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  input  logic                   wr_dc,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  input  logic                   spi_ready,
  input  logic                   spi_done,
  output logic                   spi_start,
  output logic [7:0]             spi_d_in,
  output logic                   cs,
  output logic                   dc
);

  localparam int SETUP_CYC = int'(at_least_one(CS_SETUP));
  localparam int HOLD_CYC  = int'(at_least_one(CS_HOLD));
  localparam int MAX_CYC   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC) + 1;

  // The counter runs down to zero, so a gap of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  queue_state_t     state;
  logic [CNT_W-1:0] cnt;

  oled_entry_t      wr_entry;
  oled_entry_t      head;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign wr_entry = '{dc: wr_dc, data: wr_data};

  // The head is consumed when a burst opens from IDLE and in every LOAD.
  // LOAD is entered only with a non-empty FIFO and nothing else pops in
  // between, so the head is always valid there.
  assign fifo_pop = ((state == IDLE) && !fifo_empty) || (state == LOAD);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(oled_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  // spi_d_in and dc only change when an entry is taken from the FIFO
  // (IDLE or LOAD), and both are followed by at least one cycle before the
  // start pulse, so the SPI side always sees stable byte and dc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cs        <= 1'b1;
      dc        <= 1'b0;
      spi_start <= 1'b0;
      spi_d_in  <= '0;
    end else begin
      spi_start <= 1'b0;
      case (state)
        IDLE: begin
          cs <= 1'b1;
          if (!fifo_empty) begin
            spi_d_in <= head.data;
            dc       <= head.dc;
            cs       <= 1'b0;
            cnt      <= SETUP_LOAD;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            state <= START;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        LOAD: begin
          spi_d_in <= head.data;
          dc       <= head.dc;
          state    <= START;
        end

        START: begin
          if (spi_ready) begin
            spi_start <= 1'b1;
            state     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (spi_done) begin
            if (!fifo_empty) begin
              state <= LOAD;
            end else begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          // New bytes during the hold gap continue the burst with cs low.
          if (!fifo_empty) begin
            state <= LOAD;
          end else if (cnt == '0) begin
            cs    <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          cs    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
